// File: rtl/step_phase_decoder_if.sv
// step_phase_decoder_if
// Bundles the phase-monitor bus of step_phase_decoder.
//   phase        : raw 4-bit coil pattern, asynchronous to the decoder clock
//   clear        : zeroes position and error count (lock is kept)
//   position     : signed half-step count, +1 per forward step
//   step_valid   : one-cycle pulse per accepted +/-1 step
//   step_dir     : direction of the last step, 1 = forward
//   step_period  : cycles between the last two accepted steps
//   stalled      : no step accepted for the stall timeout
//   locked       : a valid reference index is held
//   skip_err     : one-cycle pulse, jump of 2..6 indices
//   illegal_err  : one-cycle pulse, undecodable pattern
//   err_cnt      : saturating count of error pulses
// master drives phase/clear; slave is the decoder.
interface step_phase_decoder_if #(
  parameter int POS_WIDTH = 32
);
  logic [3:0]                  phase;
  logic                        clear;
  logic signed [POS_WIDTH-1:0] position;
  logic                        step_valid;
  logic                        step_dir;
  logic [31:0]                 step_period;
  logic                        stalled;
  logic                        locked;
  logic                        skip_err;
  logic                        illegal_err;
  logic [7:0]                  err_cnt;

  modport master (
    output phase, clear,
    input  position, step_valid, step_dir, step_period, stalled,
           locked, skip_err, illegal_err, err_cnt
  );

  modport slave (
    input  phase, clear,
    output position, step_valid, step_dir, step_period, stalled,
           locked, skip_err, illegal_err, err_cnt
  );
endinterface

// File: rtl/step_phase_decoder.sv
// step_phase_decoder
// Reconstructs stepper motion from a 4-bit half-step phase bus: synchronizes
// and debounces the pattern, decodes it to a half-step index, tracks
// direction, signed position and step period, and flags stalls, skipped
// phases and illegal patterns.
// Ports:
//   clk  : system clock
//   rst  : synchronous active-high reset
//   bus  : step_phase_decoder_if.slave (phase/clear in, status out)
module step_phase_decoder #(
  parameter int DEBOUNCE      = 4,
  parameter int POS_WIDTH     = 32,
  parameter int STALL_TIMEOUT = 2083334
) (
  input  logic                  clk,
  input  logic                  rst,
  step_phase_decoder_if.slave   bus
);

  typedef enum logic [1:0] {ST_UNLOCKED, ST_LOCKED, ST_IDLE} state_t;

  localparam logic [3:0]                  DEB_LIM   = 4'(DEBOUNCE);
  localparam logic [31:0]                 STALL_LIM = 32'(STALL_TIMEOUT - 1);
  localparam logic signed [POS_WIDTH-1:0] POS_ONE   = POS_WIDTH'(1);

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Returns {legal, index}.
  function automatic logic [3:0] decode(input logic [3:0] p);
    case (p)
      4'b0001: return 4'b1_000;
      4'b0011: return 4'b1_001;
      4'b0010: return 4'b1_010;
      4'b0110: return 4'b1_011;
      4'b0100: return 4'b1_100;
      4'b1100: return 4'b1_101;
      4'b1000: return 4'b1_110;
      4'b1001: return 4'b1_111;
      default: return 4'b0_000;
    endcase
  endfunction

  logic [3:0]                  sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
  logic [3:0]                  run_q, run_d;
  logic                        done_q, done_d;
  state_t                      state_q, state_d;
  logic [2:0]                  ref_q, ref_d;
  logic signed [POS_WIDTH-1:0] position_q, position_d;
  logic                        step_valid_q, step_valid_d;
  logic                        step_dir_q, step_dir_d;
  logic [31:0]                 step_period_q, step_period_d;
  logic [31:0]                 per_cnt_q, per_cnt_d;
  logic                        stalled_q, stalled_d;
  logic                        skip_err_q, skip_err_d;
  logic                        illegal_err_q, illegal_err_d;
  logic [7:0]                  err_cnt_q, err_cnt_d;

  logic       eq, accept, legal, is_idle, step;
  logic [2:0] idx, delta;
  logic [3:0] dec;

  always_comb begin
    sync1_d = bus.phase;
    sync2_d = sync1_q;
    prev_d  = sync2_q;

    // run counts consecutive cycles the synchronized pattern has matched its
    // previous value; done blocks re-acceptance until the pattern changes.
    eq     = (sync2_q == prev_q);
    run_d  = eq ? sat_inc4(run_q) : 4'd0;
    accept = eq && (run_d >= DEB_LIM) && !done_q;
    done_d = eq && (done_q || accept);

    dec     = decode(sync2_q);
    legal   = dec[3];
    idx     = dec[2:0];
    is_idle = (sync2_q == 4'b0000);
    delta   = idx - ref_q;

    state_d       = state_q;
    ref_d         = ref_q;
    step          = 1'b0;
    step_dir_d    = step_dir_q;
    skip_err_d    = 1'b0;
    illegal_err_d = 1'b0;

    if (accept) begin
      case (state_q)
        ST_UNLOCKED: begin
          if (legal) begin
            ref_d   = idx;
            state_d = ST_LOCKED;
          end else if (!is_idle) begin
            illegal_err_d = 1'b1;
          end
        end
        default: begin
          // LOCKED and IDLE judge a legal pattern the same way against ref.
          if (legal) begin
            case (delta)
              3'd0: ;
              3'd1: begin step = 1'b1; step_dir_d = 1'b1; end
              3'd7: begin step = 1'b1; step_dir_d = 1'b0; end
              default: skip_err_d = 1'b1;
            endcase
            ref_d   = idx;
            state_d = ST_LOCKED;
          end else if (is_idle) begin
            state_d = ST_IDLE;
          end else begin
            illegal_err_d = 1'b1;
            state_d       = ST_UNLOCKED;
          end
        end
      endcase
    end

    step_valid_d = step;

    // Clear overrides a coincident step on position only.
    if (bus.clear)     position_d = '0;
    else if (step)     position_d = step_dir_d ? position_q + POS_ONE : position_q - POS_ONE;
    else               position_d = position_q;

    step_period_d = step ? sat_inc32(per_cnt_q) : step_period_q;
    per_cnt_d     = step ? 32'd0 : sat_inc32(per_cnt_q);
    stalled_d     = step ? 1'b0 : (stalled_q || (per_cnt_q >= STALL_LIM));

    if (bus.clear)                       err_cnt_d = 8'd0;
    else if (skip_err_d || illegal_err_d) err_cnt_d = sat_inc8(err_cnt_q);
    else                                 err_cnt_d = err_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q       <= 4'd0;
      sync2_q       <= 4'd0;
      prev_q        <= 4'd0;
      run_q         <= 4'd0;
      done_q        <= 1'b0;
      state_q       <= ST_UNLOCKED;
      ref_q         <= 3'd0;
      position_q    <= '0;
      step_valid_q  <= 1'b0;
      step_dir_q    <= 1'b0;
      step_period_q <= 32'd0;
      per_cnt_q     <= 32'd0;
      stalled_q     <= 1'b0;
      skip_err_q    <= 1'b0;
      illegal_err_q <= 1'b0;
      err_cnt_q     <= 8'd0;
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      prev_q        <= prev_d;
      run_q         <= run_d;
      done_q        <= done_d;
      state_q       <= state_d;
      ref_q         <= ref_d;
      position_q    <= position_d;
      step_valid_q  <= step_valid_d;
      step_dir_q    <= step_dir_d;
      step_period_q <= step_period_d;
      per_cnt_q     <= per_cnt_d;
      stalled_q     <= stalled_d;
      skip_err_q    <= skip_err_d;
      illegal_err_q <= illegal_err_d;
      err_cnt_q     <= err_cnt_d;
    end
  end

  assign bus.position    = position_q;
  assign bus.step_valid  = step_valid_q;
  assign bus.step_dir    = step_dir_q;
  assign bus.step_period = step_period_q;
  assign bus.stalled     = stalled_q;
  assign bus.locked      = (state_q != ST_UNLOCKED);
  assign bus.skip_err    = skip_err_q;
  assign bus.illegal_err = illegal_err_q;
  assign bus.err_cnt     = err_cnt_q;

endmodule

// File: doc/step_phase_decoder.md
# step_phase_decoder

Monitors a 4-bit half-step motor phase bus, either the looped-back drive word or the sensed coil pattern, and reconstructs the motor motion from it. Each settled pattern is decoded to a half-step index. The block tracks direction and signed position, measures the step period, and flags stalls, skipped phases and illegal patterns. It sits on the receive side of the stepper drive path and feeds the car's odometry and fault logic.

## Interface
- DEBOUNCE, 4: consecutive cycles a synchronized pattern must hold before it is accepted (1..15).
- POS_WIDTH, 32: width of the signed position counter.
- STALL_TIMEOUT, 2083334: cycles without an accepted step before `stalled` asserts. This is twice the drive step interval.

- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- phase  in  4  coil pattern; asynchronous to clk
- clear  in  1  zeroes `position` and `err_cnt`; lock is kept
- position  out  POS_WIDTH  signed half-step count; +1 per forward step
- step_valid  out  1  one-cycle pulse per accepted ±1 step
- step_dir  out  1  direction of the last step; 1 = forward (index +1)
- step_period  out  32  cycles between the last two accepted steps
- stalled  out  1  no step for STALL_TIMEOUT cycles
- locked  out  1  a valid reference index is held
- skip_err  out  1  one-cycle pulse: jump of 2..6 indices
- illegal_err  out  1  one-cycle pulse: undecodable pattern
- err_cnt  out  8  saturating count of skip_err plus illegal_err events

## Operation
- **Input path.** `phase` passes through a 2-flop synchronizer. A stability counter compares the synchronized value with the value from the previous cycle.
  - The pattern is accepted when it has been equal for DEBOUNCE consecutive cycles.
  - Acceptance occurs once per distinct settled pattern.
- **Decode.** 0001=0, 0011=1, 0010=2, 0110=3, 0100=4, 1100=5, 1000=6, 1001=7.
  - 0000 is IDLE (coils off).
  - Every other value is illegal.
- **State machine.** Three states: UNLOCKED, LOCKED and IDLE. Reset enters UNLOCKED.
- **UNLOCKED**
  - Legal index: store it as the reference, go to LOCKED. No step is counted.
  - 0000: stay in UNLOCKED.
  - Illegal pattern: pulse `illegal_err`.
- **LOCKED**, with delta = (new − ref) mod 8 (3-bit wrap):
  - delta 1: position +1, step_dir=1, step_valid.
  - delta 7: position −1, step_dir=0, step_valid.
  - delta 0: no action.
  - delta 2..6: pulse `skip_err`; position is unchanged; ref ← new; stay in LOCKED.
  - In all legal cases, ref ← new.
  - 0000: go to IDLE; ref is retained.
  - Illegal pattern: pulse `illegal_err`, go to UNLOCKED.
- **IDLE**
  - Legal pattern: evaluate it as in LOCKED against the retained ref, then go to LOCKED.
  - Illegal pattern: pulse `illegal_err`, go to UNLOCKED.
- `locked` = 1 in LOCKED and in IDLE.
- **Position arithmetic.** Two's complement, POS_WIDTH bits. Wraps silently at ±2^(POS_WIDTH−1).
- **Period counter**
  - 32-bit, increments every cycle and saturates at 2^32−1.
  - On step_valid: step_period ← counter + 1, and the counter restarts at 0.
  - The first step after reset reports the cycles elapsed since reset.
- **Stall detection**
  - `stalled` sets when the counter reaches STALL_TIMEOUT−1 and clears on the next step_valid.
  - It is independent of state, so IDLE with no steps also stalls.
- **Error counter.** `err_cnt` increments by 1 on either error pulse and saturates at 255. The two pulses are mutually exclusive by construction.
- **Clear vs step, same cycle.** Clear wins for `position`, which becomes 0. `step_valid`, `step_dir` and `step_period` still update.
- **Clear vs error, same cycle.** `err_cnt` becomes 0.

## Timing
- **Reset values**
  - position=0, step_valid=0, step_dir=0, step_period=0.
  - stalled=0, locked=0, skip_err=0, illegal_err=0, err_cnt=0.
  - Synchronizer and stability registers are 0; state is UNLOCKED.
- **Latency.** A pattern first sampled at edge k produces step_valid, skip_err or illegal_err registered at edge k+DEBOUNCE+2. The output is visible in the cycle after that edge.
- **Glitches.** Changes shorter than DEBOUNCE cycles are ignored completely.
- **Step rate.** Maximum accepted rate is one step per DEBOUNCE+1 cycles.
- **Pulse widths.** All pulses are exactly one cycle wide. Outputs are fully registered.
- **Reset mid-operation.** Synchronous `rst` discards the pending pattern and lock. The next settled pattern relocks without counting a step.

## Test plan
- **Reset and lock.** Hold 0000, release rst, then drive 0001 for 10 cycles. Expect locked=1 at edge DEBOUNCE+3, with no step_valid and position=0.
- **Forward and wrap.** Drive index 0→1→…→7→0, holding each for 20 cycles. Expect 8 step_valid pulses, step_dir=1, position=8 and step_period=20.
- **Reverse and clear.** From index 0 drive 7,6,5. Expect position −3 (0xFFFFFFFD). Then assert clear in the same cycle as the next step: position=0 and step_valid=1.
- **Errors**
  - Drive 0001→0100: skip_err=1, err_cnt=1, position unchanged.
  - Then drive 0101: illegal_err=1, locked=0.
  - Then drive 0100 followed by 0110: the first relocks without a step; the second gives position −1.
- **Idle and glitch**
  - From index 2, drive 0000 and then 0110: a single +1 step.
  - A 2-cycle pulse to 0100 with DEBOUNCE=4 gives no output change.
- **Stall.** Set STALL_TIMEOUT=100 and stop stepping. Expect stalled=1 exactly 100 cycles after the last step_valid. It clears with the next step_valid, which reports step_period ≥ 100.
